// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, reset PC, queue depth and fetch state type.
package fetch_unit_pkg;
  localparam int PC_WIDTH = 8;
  localparam int INSTRUCTION_WIDTH = 16;
  localparam logic [PC_WIDTH-1:0] RESET_PC = '0;
  localparam int QUEUE_DEPTH = 2;
  typedef enum logic {RUN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with flush; flush overrides push and pop.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + (AW+1)'(1);
      if (pop_i) rd_q <= rd_q + (AW+1)'(1);
    end
  end
  always_ff @(posedge clock) begin
    if (push_i && !flush_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  // Empty head reads as zero so out_* are clean after reset and flush.
  assign data_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and fetch queue feeding the decoder, with redirect and halt.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  output logic [PC_WIDTH-1:0]          pc,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
  output logic [PC_WIDTH-1:0]          out_pc,
  input  logic                         redirect_valid,
  input  logic [PC_WIDTH-1:0]          redirect_pc,
  input  logic                         halt_request,
  output logic                         halted
);
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  fetch_state_t state_q, state_d;
  logic full, empty, pop, fetch;
  fetch_queue #(.DEPTH(QUEUE_DEPTH), .WIDTH(PC_WIDTH + INSTRUCTION_WIDTH)) u_queue (
    .clock   (clock),
    .reset   (reset),
    .push_i  (fetch),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_i  ({pc_q, instruction}),
    .data_o  ({out_pc, out_instruction}),
    .full_o  (full),
    .empty_o (empty)
  );
  assign pop = !empty && out_ready;
  assign fetch = state_q == RUN && !redirect_valid && !halt_request && (!full || pop);
  always_comb begin
    pc_d = redirect_valid ? redirect_pc : fetch ? pc_q + PC_WIDTH'(1) : pc_q;
    state_d = redirect_valid ? RUN : halt_request ? HALT : state_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q <= pc_d;
      state_q <= state_d;
    end
  end
  assign pc = pc_q;
  assign out_valid = !empty;
  assign halted = state_q == HALT && empty;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus checked against a queue-based model.
module tb_fetch_unit;
  logic clock, reset;
  logic [7:0] pc, out_pc, redirect_pc;
  logic [15:0] instruction, out_instruction;
  logic out_valid, out_ready, redirect_valid, halt_request, halted;
  int checks = 0, errors = 0;
  int m_pc;
  bit m_halt;
  int m_q[$];

  fetch_unit dut (
    .clock(clock), .reset(reset), .pc(pc), .instruction(instruction),
    .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
    .out_pc(out_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_request(halt_request), .halted(halted)
  );

  function automatic int mem(int a);
    return a + 'h100;
  endfunction

  assign instruction = 16'(mem(int'(pc)));

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(bit rs, bit rdy, bit rv, int rp, bit hr);
    bit popv, fet;
    reset = rs; out_ready = rdy; redirect_valid = rv; redirect_pc = 8'(rp); halt_request = hr;
    if (rs) begin
      m_q.delete(); m_pc = 0; m_halt = 0;
    end else if (rv) begin
      m_q.delete(); m_pc = rp; m_halt = 0;
    end else begin
      popv = m_q.size() > 0 && rdy;
      fet = !m_halt && !hr && (m_q.size() < 2 || popv);
      if (popv) void'(m_q.pop_front());
      if (fet) begin
        m_q.push_back((m_pc << 16) | mem(m_pc));
        m_pc = (m_pc + 1) % 256;
      end
      if (hr) m_halt = 1;
    end
    @(posedge clock);
    #1;
    chk("pc", int'(pc), m_pc);
    chk("out_valid", int'(out_valid), int'(m_q.size() > 0));
    chk("out_pc", int'(out_pc), m_q.size() > 0 ? (m_q[0] >> 16) : 0);
    chk("out_instruction", int'(out_instruction), m_q.size() > 0 ? (m_q[0] & 'hFFFF) : 0);
    chk("halted", int'(halted), int'(m_halt && m_q.size() == 0));
  endtask

  initial begin
    reset = 1; out_ready = 0; redirect_valid = 0; redirect_pc = 0; halt_request = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 'h40, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
    chk("pc_at_halt", int'(pc), 5);
    cyc(0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 1, 'h10, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 'hFE, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 'h80, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 255), $urandom_range(0, 24) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
